// File: rtl/cluster_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : cluster_unpacker
// Brief    : Expands serial (address, size) cluster words back into a 768-bit
//            s-bit map, accumulated per frame and emitted on the next frame.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_unpacker #(
    parameter int MXCLUSTERS = 8,
    parameter int MXADR      = 768
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         frame_start,
    input  logic         cluster_valid,
    input  logic [10:0]  cluster_adr,
    input  logic [2:0]   cluster_cnt,
    output logic [767:0] vpfs_out,
    output logic         vpfs_valid,
    output logic         overflow,
    output logic [7:0]   overflow_cnt,
    output logic [7:0]   bad_adr_cnt
);

    localparam int                c_MAP_W   = 768;
    localparam int                c_CNT_W   = $clog2(MXCLUSTERS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MXCLUSTERS);
    localparam logic [11:0]       c_MXADR   = 12'(MXADR);
    localparam logic [7:0]        c_SAT     = 8'hFF;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ACCUM = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_MAP_W-1:0] r_work;
    logic [c_CNT_W-1:0] r_count;
    logic               r_frame_ovf;
    logic [c_MAP_W-1:0] r_vpfs;
    logic               r_vpfs_valid;
    logic               r_overflow;
    logic [7:0]         r_ovf_cnt;
    logic [7:0]         r_bad_cnt;

    logic [7:0]         w_span;
    logic [c_MAP_W-1:0] w_mask;
    logic               w_adr_ok;
    logic               w_take;
    logic               w_full;
    logic               w_drop;
    logic               w_accept;
    logic               w_bad;
    logic               w_emit;
    logic [c_MAP_W-1:0] w_base_map;
    logic [c_CNT_W-1:0] w_base_cnt;
    logic               w_base_fovf;
    logic [c_MAP_W-1:0] w_next_map;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               w_next_fovf;

    // Run of cnt+1 ones shifted to adr; bits beyond the top fall off, so no wrap.
    always_comb begin
        w_span   = 8'hFF >> (3'd7 - cluster_cnt);
        w_mask   = {{(c_MAP_W-8){1'b0}}, w_span} << cluster_adr;
        w_adr_ok = ({1'b0, cluster_adr} < c_MXADR);
    end

    // A frame_start opens a fresh frame, so any same-cycle cluster lands in the new one.
    always_comb begin
        w_take      = cluster_valid && (r_state == c_ST_ACCUM);
        w_emit      = frame_start && (r_state == c_ST_ACCUM);
        w_base_map  = frame_start ? '0 : r_work;
        w_base_cnt  = frame_start ? '0 : r_count;
        w_base_fovf = frame_start ? 1'b0 : r_frame_ovf;
        w_full      = (w_base_cnt == c_MAX_CNT);
        w_drop      = w_take && w_full;
        w_accept    = w_take && !w_full;
        w_bad       = w_accept && !w_adr_ok;
        w_next_map  = w_base_map | ((w_accept && w_adr_ok) ? w_mask : '0);
        w_next_cnt  = w_base_cnt + c_CNT_W'(w_accept);
        w_next_fovf = w_base_fovf | w_drop;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = c_ST_ACCUM;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_work       <= '0;
            r_count      <= '0;
            r_frame_ovf  <= 1'b0;
            r_vpfs       <= '0;
            r_vpfs_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_ovf_cnt    <= '0;
            r_bad_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_work       <= w_next_map;
            r_count      <= w_next_cnt;
            r_frame_ovf  <= w_next_fovf;
            r_vpfs_valid <= w_emit;
            if (w_emit) begin
                r_vpfs     <= r_work;
                r_overflow <= r_frame_ovf;
            end
            if (w_drop && (r_ovf_cnt != c_SAT)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
            if (w_bad && (r_bad_cnt != c_SAT)) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    assign vpfs_out     = r_vpfs;
    assign vpfs_valid   = r_vpfs_valid;
    assign overflow     = r_overflow;
    assign overflow_cnt = r_ovf_cnt;
    assign bad_adr_cnt  = r_bad_cnt;

endmodule
`default_nettype wire

// File: doc/cluster_unpacker.md
# cluster_unpacker

Rebuilds a 768-bit s-bit map from the serial cluster stream produced by the cluster packer: each cluster word (address + size) is expanded back into set bits, accumulated over one frame, and presented as a registered 768-bit map once per frame. It is the receive-side inverse of the packing chain (truncation + priority encoding). It is used in loopback checking and in downstream trigger emulation.

## Interface
Parameters:
- MXCLUSTERS, 8: maximum clusters accepted per frame; further clusters are dropped.
- MXADR, 768: number of valid strip addresses; address ≥ MXADR is invalid.

Ports:
- clock  in  1  fabric clock (160 MHz); sole clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle strobe marking the first cycle of a new frame.
- cluster_valid  in  1  cluster word present this cycle.
- cluster_adr  in  11  first (least-significant) strip of the cluster.
- cluster_cnt  in  3  cluster size minus one (1..8 strips).
- vpfs_out  out  768  reconstructed map of the last completed frame.
- vpfs_valid  out  1  one-cycle pulse when vpfs_out updates.
- overflow  out  1  sticky-per-frame flag: the completed frame had > MXCLUSTERS clusters.
- overflow_cnt  out  8  saturating count of dropped clusters since reset.
- bad_adr_cnt  out  8  saturating count of clusters with address ≥ MXADR since reset.

## Operation
- States: IDLE (after reset, no open frame) and ACCUM (frame open).
- IDLE: cluster_valid is ignored and not counted; frame_start -> ACCUM with a cleared work map and cluster counter; no vpfs_valid.
- ACCUM, cluster_valid=1, adr < MXADR, count < MXCLUSTERS: set work bits adr .. min(adr+cnt, MXADR-1) (no wrap past 767); increment the per-frame count.
- adr ≥ MXADR: no bits set; bad_adr_cnt++ (saturate at 255); counts toward MXCLUSTERS.
- Count already = MXCLUSTERS: cluster dropped; overflow_cnt++ (saturate at 255); the frame's overflow flag is set.
- Overlapping clusters OR together; duplicates are harmless.
- ACCUM, frame_start: vpfs_out <= work map including any cluster accepted this same cycle? No — a cluster arriving with frame_start belongs to the NEW frame. The closing frame is the work map as of the previous cycle. The work map and count are cleared, then the simultaneous cluster is applied. overflow <= the frame's overflow flag. The frame flag is cleared.
- reset: vpfs_out = 0, vpfs_valid = 0, overflow = 0, both counters = 0, work map = 0, state = IDLE. Reset mid-frame discards the partial frame; the first frame_start after reset emits nothing.

## Timing
- frame_start in ACCUM at cycle T -> vpfs_out / overflow updated and vpfs_valid = 1 at T+1 (registered); vpfs_valid is low at T+2 unless another frame_start occurred at T+1.
- Latency: a cluster accepted at cycle C appears in vpfs_out one cycle after the next frame_start.
- vpfs_out holds its value between frames.
- Throughput: one cluster per clock. Nominal frame = 4 clocks; longer frames are legal.
- Counters update the cycle after the offending cluster.
- Bit expansion is a decoded mask (adr, cnt) -> 768 bits. It may be pipelined internally by at most 1 stage, provided the frame boundary semantics above and the T+1 output latency are preserved (the pipeline must drain into the closing frame).

## Test plan
- Reset, frame_start, cluster (adr=5, cnt=2), frame_start -> vpfs_out bits 5,6,7 set only, vpfs_valid one pulse, overflow=0.
- Cluster adr=766 cnt=7 -> bits 766,767 only; no wrap to bit 0. Cluster adr=800 -> no bits; bad_adr_cnt=1.
- 10 valid clusters in one frame with MXCLUSTERS=8 -> first 8 reflected; overflow=1 with that frame; overflow_cnt=2. The next clean frame -> overflow=0, overflow_cnt stays 2.
- Cluster coincident with frame_start -> absent from the closing frame's vpfs_out, present in the following frame.
- Assert reset mid-frame after 3 clusters -> outputs zero. The next frame_start emits nothing; the second frame_start emits only the post-reset clusters.
- 300 invalid addresses -> bad_adr_cnt saturates at 255. A random loopback of truncate-and-encode output -> the reconstructed map equals the original for frames with ≤ MXCLUSTERS clusters.
